// File: rtl/cpu_fetch.sv
// cpu_fetch: next-PC select, instruction memory read issue and a small response queue to decode.
// Optional performance counters are built when CPU_FETCH_PERF_EN is defined.
module cpu_fetch #(
  parameter int          INSTR_W = 32,
  parameter int          DEPTH   = 4,
  parameter logic [15:0] PC_STEP = 16'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [15:0]        pc_in,
  output logic [15:0]        pc_next,
  output logic               imem_ren,
  output logic [15:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  output logic               fq_valid,
  input  logic               fq_ready,
  output logic [INSTR_W-1:0] fq_instr,
  output logic [15:0]        fq_pc
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               inflight_q, inflight_d;
  logic [15:0]        infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [15:0]        pc_mem_q [DEPTH];
  logic [15:0]        pc_mem_d [DEPTH];

  logic [CNT_W-1:0]   occupancy;
  logic               credit_ok;
  logic               enq;
  logic               deq;

  // Occupancy counts the in-flight read so a returning response always has a slot.
  assign occupancy = count_q + CNT_W'(inflight_q);
  assign credit_ok = (occupancy < CNT_W'(DEPTH));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs; pc_next follows pc_in while reset is held
  always_comb begin
    imem_ren = 1'b0;
    pc_next  = pc_in;
    if (!rst) begin
      if ((state_q == ST_RUN) && fetch_en && !redirect_valid && credit_ok) begin
        imem_ren = 1'b1;
      end
      if (redirect_valid) begin
        pc_next = redirect_pc;
      end else if (imem_ren) begin
        pc_next = pc_in + PC_STEP;
      end
    end
  end

  assign imem_addr = pc_in;

  // Queue and in-flight tracking
  always_comb begin
    enq         = inflight_q & ~redirect_valid;
    deq         = fq_valid & fq_ready;
    inflight_d  = imem_ren;
    infl_pc_d   = imem_ren ? pc_in : infl_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = infl_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      inflight_q  <= inflight_d;
      infl_pc_q   <= infl_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  assign fq_valid = (count_q != '0);
  assign fq_instr = instr_mem_q[rd_ptr_q];
  assign fq_pc    = pc_mem_q[rd_ptr_q];

`ifdef CPU_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate; a redirect cycle is not counted as a credit stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == ST_RUN) && fetch_en && !redirect_valid && !credit_ok &&
        (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect_valid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: randomized and directed bench for cpu_fetch against a queue-based reference model.
// Also exercises the perf counters when CPU_FETCH_PERF_EN is defined.
module tb_cpu_fetch;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fetch_en = 1'b0;
  logic [15:0]        pc_in;
  logic [15:0]        pc_next;
  logic               imem_ren;
  logic [15:0]        imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid = 1'b0;
  logic [15:0]        redirect_pc = 16'h0;
  logic               fq_valid;
  logic               fq_ready = 1'b0;
  logic [INSTR_W-1:0] fq_instr;
  logic [15:0]        fq_pc;
`ifdef CPU_FETCH_PERF_EN
  logic [31:0]        perf_stall_cnt;
  logic [15:0]        perf_flush_cnt;
`endif

  logic [15:0]  pc_init = 16'h0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [159:0] obs;
  logic [159:0] exp_v;

  cpu_fetch #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_STEP(16'd4)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_in(pc_in), .pc_next(pc_next),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_instr(fq_instr), .fq_pc(fq_pc)
`ifdef CPU_FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  // PC register and one-cycle-latency instruction memory around the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) pc_in <= pc_init;
    else     pc_in <= pc_next;
  end

  always @(posedge clk) begin
    imem_rdata <= imem_ren ? memf(imem_addr) : $urandom;
  end

  // Reference model: a queue of {pc, instr}, one outstanding read and a running flag.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_run;
  bit          m_infl;
  logic [15:0] m_infl_pc;
  logic [31:0] m_stall;
  logic [15:0] m_flush;
  logic        exp_ren;
  logic [15:0] exp_pc_next;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_infl = 0; m_infl_pc = 16'h0;
    m_stall = 32'h0; m_flush = 16'h0;
  endtask

  task automatic model_eval();
    exp_ren = m_run && fetch_en && !redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
    exp_pc_next = redirect_valid ? redirect_pc : (exp_ren ? pc_in + 16'd4 : pc_in);
  endtask

  task automatic model_advance();
    model_eval();
    if (m_run && fetch_en && !redirect_valid && ((mq.size() + int'(m_infl)) >= DEPTH) &&
        m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 32'd1;
    if (redirect_valid) begin
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      mq.delete();
      m_infl = 0;
    end else begin
      if (mq.size() > 0 && fq_ready) void'(mq.pop_front());
      if (m_infl) mq.push_back(ent_t'{pc: m_infl_pc, instr: memf(m_infl_pc)});
      m_infl    = exp_ren;
      m_infl_pc = pc_in;
    end
    m_run = 1;
  endtask

  function automatic logic [159:0] dut_vec();
    logic [159:0] v = '0;
    v[81:0] = {imem_ren, pc_next, imem_addr, fq_valid,
               fq_valid ? fq_pc : 16'h0, fq_valid ? fq_instr : 32'h0};
`ifdef CPU_FETCH_PERF_EN
    v[129:82] = {perf_stall_cnt, perf_flush_cnt};
`endif
    return v;
  endfunction

  function automatic logic [159:0] model_vec();
    logic [159:0] v = '0;
    logic         ev = (mq.size() > 0);
    v[81:0] = {exp_ren, exp_pc_next, pc_in, ev,
               ev ? mq[0].pc : 16'h0, ev ? mq[0].instr : 32'h0};
`ifdef CPU_FETCH_PERF_EN
    v[129:82] = {m_stall, m_flush};
`endif
    return v;
  endfunction

  task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [15:0] rpc);
    fetch_en = fe; fq_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
  endtask

  // Leaves the bench at a falling edge with reset just released (first cycle is IDLE).
  task automatic do_reset(input logic [15:0] pc0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    pc_init = pc0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pc_init = 16'h0;
    drive(1'b1, 1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    #1;
    n_checks++; if (fq_valid !== 1'b0) $display("FAIL reset_fq_valid got=%b exp=0", fq_valid); else n_pass++;
    n_checks++; if (imem_ren !== 1'b0) $display("FAIL reset_imem_ren got=%b exp=0", imem_ren); else n_pass++;
    n_checks++; if (fq_instr !== 32'h0) $display("FAIL reset_fq_instr got=%h exp=0", fq_instr); else n_pass++;
    n_checks++; if (fq_pc !== 16'h0) $display("FAIL reset_fq_pc got=%h exp=0", fq_pc); else n_pass++;
    n_checks++; if (pc_next !== 16'h0000) $display("FAIL reset_pc_next got=%h exp=0000", pc_next); else n_pass++;
`ifdef CPU_FETCH_PERF_EN
    n_checks++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 48'h0)
      $display("FAIL reset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_flush_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_stream();
    logic [15:0] hs[$];
    int first_valid = -1;
    bit seq_ok = 1;
    do_reset(16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 24; i++) begin
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (fq_valid && first_valid < 0) first_valid = i;
      if (fq_valid && fq_ready) hs.push_back(fq_pc);
      model_advance();
      @(negedge clk);
    end
    n_checks++; if (first_valid !== 3) $display("FAIL stream_first_valid got=%0d exp=3", first_valid); else n_pass++;
    foreach (hs[k]) if (hs[k] !== 16'(4 * k)) seq_ok = 0;
    n_checks++;
    if (hs.size() !== 21 || !seq_ok) $display("FAIL stream_seq got=%0d/ok%0d exp=21/ok1", hs.size(), seq_ok);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] hs[$];
    int ren_cnt = 0;
    logic [47:0] got;
    do_reset(16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL bp_fill cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (imem_ren) ren_cnt++;
      model_advance();
      @(negedge clk);
    end
    #1;
    n_checks++; if (ren_cnt !== 4) $display("FAIL bp_reads got=%0d exp=4", ren_cnt); else n_pass++;
    n_checks++;
    if ({imem_ren, pc_in, pc_next} !== {1'b0, 16'h0010, 16'h0010})
      $display("FAIL bp_hold got=%b/%h/%h exp=0/0010/0010", imem_ren, pc_in, pc_next);
    else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (fq_valid && fq_ready) hs.push_back(fq_pc);
      model_advance();
      @(negedge clk);
    end
    got = '1;
    if (hs.size() >= 5) got = {hs[0], hs[3], hs[4]};
    n_checks++;
    if (got !== {16'h0000, 16'h000C, 16'h0010}) $display("FAIL bp_order got=%h exp=0000000c0010", got);
    else n_pass++;
  endtask

  task automatic test_redirect();
    int first_valid = -1;
    logic [15:0] first_pc = 16'hDEAD;
    do_reset(16'h0000);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i > 5), (i == 5), 16'h0100);
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL redir_model cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (i > 5 && fq_valid && first_valid < 0) begin
        first_valid = i;
        first_pc    = fq_pc;
      end
      model_advance();
      @(negedge clk);
    end
    n_checks++;
    if (first_valid !== 8 || first_pc !== 16'h0100)
      $display("FAIL redir_latency got=cyc%0d/%h exp=cyc8/0100", first_valid, first_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] hs[$];
    logic [47:0] got;
    do_reset(16'h0000);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, (i == 0), 16'hFFF8);
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (fq_valid && fq_ready) hs.push_back(fq_pc);
      model_advance();
      @(negedge clk);
    end
    got = '1;
    if (hs.size() >= 3) got = {hs[0], hs[1], hs[2]};
    n_checks++;
    if (got !== {16'hFFF8, 16'hFFFC, 16'h0000}) $display("FAIL wrap_seq got=%h exp=fff8fffc0000", got);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [15:0] hs[$];
    int first_valid = -1;
    logic [47:0] got;
    do_reset(16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL midrst_fill cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      model_advance();
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fq_valid, imem_ren} !== 2'b00) $display("FAIL midrst_async got=%b%b exp=00", fq_valid, imem_ren);
    else n_pass++;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL midrst_run cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      if (fq_valid && first_valid < 0) first_valid = i;
      if (fq_valid && fq_ready) hs.push_back(fq_pc);
      model_advance();
      @(negedge clk);
    end
    got = '1;
    if (hs.size() >= 3) got = {hs[0], hs[1], hs[2]};
    n_checks++;
    if (first_valid !== 3 || got !== {16'h0000, 16'h0004, 16'h0008})
      $display("FAIL midrst_restart got=cyc%0d/%h exp=cyc3/000000040008", first_valid, got);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(16'($urandom) & 16'hFFFC);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, 16'($urandom) & 16'hFFFC);
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      model_advance();
      @(negedge clk);
    end
  endtask

`ifdef CPU_FETCH_PERF_EN
  task automatic test_perf();
    do_reset(16'h0000);
    for (int i = 0; i < 13; i++) begin
      if (i < 10)       drive(1'b1, 1'b0, 1'b0, 16'h0);
      else if (i < 12)  drive(1'b0, 1'b0, 1'b1, 16'h0200);
      else              drive(1'b0, 1'b0, 1'b0, 16'h0);
      #1;
      model_eval(); obs = dut_vec(); exp_v = model_vec();
      n_checks++; if (obs !== exp_v) $display("FAIL perf_model cyc=%0d got=%h exp=%h", i, obs, exp_v); else n_pass++;
      model_advance();
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 16'd2)
      $display("FAIL perf_counts got=%0d/%0d exp=5/2", perf_stall_cnt, perf_flush_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midop();
    test_random();
`ifdef CPU_FETCH_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
